// File: rtl/nat_pkg.sv
// rtl/nat_pkg.sv - shared constants, state encoding and helpers for the NAT lookup arbiter
package nat_pkg;

    localparam int NAT_BEATS = 4;
    localparam int NAT_ID_W  = 32;

    // Beat position of each 5-tuple field within one lookup request
    localparam int BEAT_SRCIP = 0;
    localparam int BEAT_DSTIP = 1;
    localparam int BEAT_PORTS = 2;
    localparam int BEAT_PROTO = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } nat_state_e;

    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/nat_rr_pick.sv
// rtl/nat_rr_pick.sv - round-robin first-valid search starting at rr_ptr
module nat_rr_pick
    import nat_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rotated;
    int                 pos;

    // Rotating the doubled vector puts rr_ptr at bit 0, so a plain low-first search is fair
    always_comb begin
        dbl     = {req_i, req_i};
        rotated = N_REQ'(dbl >> rr_ptr_i);
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                found_o = 1'b1;
                pos     = int'(rr_ptr_i) + j;
                if (pos >= N_REQ) begin
                    pos = pos - N_REQ;
                end
                idx_o = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/nat_lookup_arbiter.sv
// rtl/nat_lookup_arbiter.sv - round-robin sharing of one NAT lookup engine between requesters
module nat_lookup_arbiter
    import nat_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = NAT_ID_W,
    parameter int BEATS  = NAT_BEATS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    input  logic [N_REQ-1:0]         rsp_ready_i,
    output logic                     tuple_valid_o,
    output logic [DATA_W-1:0]        tuple_data_o,
    input  logic                     tuple_ready_i,
    input  logic                     conn_valid_i,
    input  logic [DATA_W-1:0]        conn_data_i,
    output logic                     conn_ready_o,
    output logic [$clog2(N_REQ)-1:0] grant_o,
    output logic                     busy_o,
    output logic [31:0]              lookups_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BC_W  = $clog2(BEATS);

    nat_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic [31:0]       lookups_q, lookups_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_valid;
    logic [DATA_W-1:0] owner_data;
    logic              fwd_xfer;

    nat_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    assign owner_valid = req_valid_i[grant_q];
    assign owner_data  = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
    assign fwd_xfer    = (state_q == ST_FWD) && owner_valid && tuple_ready_i;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        rsp_d      = rsp_q;
        lookups_d  = lookups_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                // The grant stays locked until the whole tuple is through, even if the owner stalls
                if (fwd_xfer) begin
                    if (beat_cnt_q == BC_W'(BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (conn_valid_i) begin
                    rsp_d   = conn_data_i;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i[grant_q]) begin
                    lookups_d = lookups_q + 32'd1;
                    rr_ptr_d  = IDX_W'(rr_wrap_inc(int'(grant_q), N_REQ));
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            rsp_q      <= '0;
            lookups_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rsp_q      <= rsp_d;
            lookups_q  <= lookups_d;
        end
    end

    always_comb begin
        tuple_valid_o = 1'b0;
        tuple_data_o  = '0;
        req_ready_o   = '0;
        conn_ready_o  = 1'b0;
        rsp_valid_o   = '0;
        rsp_data_o    = '0;
        case (state_q)
            ST_FWD: begin
                tuple_valid_o        = owner_valid;
                tuple_data_o         = owner_data;
                req_ready_o[grant_q] = tuple_ready_i;
            end
            ST_WAIT: conn_ready_o = 1'b1;
            ST_RSP: begin
                rsp_valid_o[grant_q] = 1'b1;
                rsp_data_o           = rsp_q;
            end
            default: ;
        endcase
    end

    assign grant_o   = grant_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign lookups_o = lookups_q;

endmodule

// File: tb/tb_nat_lookup_arbiter.sv
// tb/tb_nat_lookup_arbiter.sv - directed table-driven bench with requester and engine models
module tb_nat_lookup_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int PROBE = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_data_o;
    logic [N-1:0]    rsp_ready_i;
    logic            tuple_valid_o;
    logic [DW-1:0]   tuple_data_o;
    logic            tuple_ready_i;
    logic            conn_valid_i;
    logic [DW-1:0]   conn_data_i;
    logic            conn_ready_o;
    logic [1:0]      grant_o;
    logic            busy_o;
    logic [31:0]     lookups_o;

    nat_lookup_arbiter #(.N_REQ(N), .DATA_W(DW), .BEATS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_data_o    (rsp_data_o),
        .rsp_ready_i   (rsp_ready_i),
        .tuple_valid_o (tuple_valid_o),
        .tuple_data_o  (tuple_data_o),
        .tuple_ready_i (tuple_ready_i),
        .conn_valid_i  (conn_valid_i),
        .conn_data_i   (conn_data_i),
        .conn_ready_o  (conn_ready_o),
        .grant_o       (grant_o),
        .busy_o        (busy_o),
        .lookups_o     (lookups_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  req;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [31:0] b3;
        logic [31:0] id;
    } vec_t;

    vec_t tbl [8];

    int total = 0;
    int bad   = 0;

    logic [31:0] rq_data [N][64];
    int          rq_head [N];
    int          rq_tail [N];
    int          sent    [N];
    int          hold_at [N];
    int          hold_len[N];
    logic [31:0] xb_data [128];
    int          xb_head, xb_tail;
    logic [31:0] eid [32];
    int          eid_head, eid_tail;
    int          xr_req [32];
    logic [31:0] xr_id  [32];
    int          xr_head, xr_tail;
    int          eng_rx, eng_cnt;
    logic        eng_cv;
    logic        spurious;
    int          rsp_hold, rsp_hold_req;
    logic [N-1:0] hs_req, dropping;
    logic        tx, conn_hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            rq_head[k] = 0; rq_tail[k] = 0; sent[k] = 0; hold_at[k] = 0; hold_len[k] = 0;
        end
        xb_head = 0; xb_tail = 0; eid_head = 0; eid_tail = 0; xr_head = 0; xr_tail = 0;
        eng_rx = 0; eng_cnt = 0; eng_cv = 1'b0; spurious = 1'b0;
        rsp_hold = 0; rsp_hold_req = 0;
        hs_req = '0; dropping = '0; tx = 1'b0; conn_hs = 1'b0;
    endtask

    task automatic push_lookup(input int r, input logic [31:0] b0, input logic [31:0] b1,
                               input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] id);
        rq_data[r][rq_tail[r]]     = b0;
        rq_data[r][rq_tail[r] + 1] = b1;
        rq_data[r][rq_tail[r] + 2] = b2;
        rq_data[r][rq_tail[r] + 3] = b3;
        rq_tail[r] += 4;
        xb_data[xb_tail] = b0; xb_data[xb_tail + 1] = b1;
        xb_data[xb_tail + 2] = b2; xb_data[xb_tail + 3] = b3;
        xb_tail += 4;
        eid[eid_tail] = id; eid_tail++;
        xr_req[xr_tail] = r; xr_id[xr_tail] = id; xr_tail++;
    endtask

    function automatic bit model_idle();
        bit idle = (xr_head == xr_tail);
        for (int k = 0; k < N; k++) begin
            if (rq_head[k] < rq_tail[k]) idle = 1'b0;
        end
        return idle;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k] = (rq_head[k] < rq_tail[k]) && !(hold_len[k] > 0 && sent[k] == hold_at[k]);
            req_data_i[k*DW +: DW] = (rq_head[k] < rq_tail[k]) ? rq_data[k][rq_head[k]] : '0;
        end
        tuple_ready_i = (eng_rx < 4);
        conn_valid_i  = eng_cv | spurious;
        conn_data_i   = eng_cv ? eid[eid_head] : (spurious ? 32'h0000DEAD : 32'h0);
        rsp_ready_i   = '1;
        if (rsp_hold > 0) rsp_ready_i[rsp_hold_req] = 1'b0;
    endtask

    task automatic observe();
        logic [N-1:0] own_mask;
        for (int k = 0; k < N; k++) begin
            dropping[k] = (rq_head[k] < rq_tail[k]) && hold_len[k] > 0 && sent[k] == hold_at[k];
            hs_req[k]   = req_valid_i[k] & req_ready_o[k];
        end
        tx      = tuple_valid_o & tuple_ready_i;
        conn_hs = eng_cv & conn_ready_o;
        own_mask = '1;
        if (busy_o && xr_head < xr_tail) own_mask = ~(4'b0001 << xr_req[xr_head]);
        chk("req_ready_not_owner", req_ready_o & own_mask, 0);
        if (tx) begin
            if (xb_head < xb_tail) begin
                chk("tuple_beat", tuple_data_o, xb_data[xb_head]);
                xb_head++;
            end else begin
                chk("tuple_unexpected", tuple_valid_o, 0);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (dropping[k]) begin
                chk("hold_grant", grant_o, k);
                chk("hold_tuple_valid", tuple_valid_o, 0);
                chk("hold_other_ready", req_ready_o & ~(4'b0001 << k), 0);
            end
        end
        if (rsp_valid_o == '0) begin
            chk("rsp_data_zero", rsp_data_o, 0);
        end else if ((rsp_valid_o & rsp_ready_i) == '0) begin
            chk("stall_rsp_valid", rsp_valid_o, 4'b0001 << rsp_hold_req);
            chk("stall_rsp_data", rsp_data_o, xr_id[xr_head]);
            chk("stall_conn_ready", conn_ready_o, 0);
            chk("stall_grant", grant_o, rsp_hold_req);
            if (rsp_hold > 0) rsp_hold--;
        end else if (xr_head < xr_tail) begin
            chk("rsp_onehot", rsp_valid_o, 4'b0001 << xr_req[xr_head]);
            chk("rsp_data", rsp_data_o, xr_id[xr_head]);
            chk("rsp_grant", grant_o, xr_req[xr_head]);
            xr_head++;
        end else begin
            chk("rsp_unexpected", rsp_valid_o, 0);
        end
    endtask

    task automatic update();
        for (int k = 0; k < N; k++) begin
            if (hs_req[k]) begin
                rq_head[k]++;
                sent[k] = (sent[k] + 1) % 4;
            end
            if (dropping[k]) hold_len[k]--;
        end
        if (conn_hs) begin
            eng_cv = 1'b0; eng_rx = 0; eid_head++;
        end else if (tx) begin
            eng_rx++;
            if (eng_rx == 4) eng_cnt = PROBE;
        end else if (eng_rx == 4 && !eng_cv) begin
            if (eng_cnt == 0) eng_cv = 1'b1;
            else eng_cnt--;
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        if (rst_n) observe();
        @(posedge clk);
        if (rst_n) update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while (!(model_idle() && !busy_o) && n < max) begin
            cycle();
            n++;
        end
        chk("run_pending_rsp", xr_tail - xr_head, 0);
    endtask

    task automatic wait_busy(input int max);
        int n = 0;
        while (!busy_o && n < max) begin
            cycle();
            n++;
        end
        chk("wait_busy", busy_o, 1);
    endtask

    initial begin
        tbl[0] = '{3'd0, 32'hC0A80001, 32'h08080808, 32'h00351001, 32'h00000011, 32'h00001000};
        tbl[1] = '{3'd1, 32'hC0A80002, 32'h01010101, 32'h01BB2002, 32'h00000006, 32'h00001001};
        tbl[2] = '{3'd2, 32'hC0A80003, 32'h09090909, 32'h00503003, 32'h00000006, 32'h00001002};
        tbl[3] = '{3'd3, 32'hC0A80004, 32'h04040404, 32'h00164004, 32'h00000011, 32'h00001003};
        tbl[4] = '{3'd0, 32'hAC100005, 32'h05050505, 32'h00195005, 32'h00000006, 32'h00001004};
        tbl[5] = '{3'd1, 32'hAC100006, 32'h06060606, 32'h007B6006, 32'h00000011, 32'h00001005};
        tbl[6] = '{3'd2, 32'hAC100007, 32'h07070707, 32'h00357007, 32'h00000011, 32'h00001006};
        tbl[7] = '{3'd3, 32'hAC100008, 32'h0A0A0A0A, 32'h01BB8008, 32'h00000006, 32'h00001007};

        rst_n = 1'b0;
        clear_model();
        drive();
        @(negedge clk);
        do_reset();

        drive();
        #1;
        chk("rst_tuple_valid", tuple_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_conn_ready", conn_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_lookups", lookups_o, 0);

        push_lookup(0, 32'h0A000001, 32'h0A000002, 32'h00500400, 32'h00000006, 32'h00000155);
        run_idle(200);
        chk("t1_lookups", lookups_o, 1);
        chk("t1_grant", grant_o, 0);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_lookup(int'(tbl[i].req), tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, tbl[i].id);
        end
        run_idle(1000);
        chk("t2_lookups", lookups_o, 8);
        chk("t2_last_grant", grant_o, 3);

        hold_at[2]  = 2;
        hold_len[2] = 5;
        push_lookup(2, 32'h0A000302, 32'h0A000402, 32'h1F901F40, 32'h00000006, 32'h00002222);
        wait_busy(20);
        chk("t3_grant", grant_o, 2);
        push_lookup(1, 32'h0A000301, 32'h0A000401, 32'h1F911F41, 32'h00000011, 32'h00001111);
        run_idle(300);
        chk("t3_hold_elapsed", hold_len[2], 0);
        chk("t3_lookups", lookups_o, 10);

        rsp_hold_req = 1;
        rsp_hold     = 10;
        push_lookup(1, 32'h0A000501, 32'h0A000601, 32'h22B822B9, 32'h00000006, 32'h00004444);
        wait_busy(20);
        push_lookup(0, 32'h0A000500, 32'h0A000600, 32'h22BA22BB, 32'h00000011, 32'h00005555);
        run_idle(300);
        chk("t4_stall_elapsed", rsp_hold, 0);
        chk("t4_lookups", lookups_o, 12);

        spurious = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_rsp_valid", rsp_valid_o, 0);
            chk("t6_busy", busy_o, 0);
        end
        spurious = 1'b0;
        cycle();
        chk("t6_lookups", lookups_o, 12);

        push_lookup(3, 32'h0A000703, 32'h0A000803, 32'h30393039, 32'h00000006, 32'h00003333);
        begin
            int n = 0;
            while (eng_rx < 2 && n < 50) begin
                cycle();
                n++;
            end
        end
        chk("t5_beats_in", eng_rx, 2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        drive();
        #1;
        chk("t5_busy", busy_o, 0);
        chk("t5_tuple_valid", tuple_valid_o, 0);
        chk("t5_req_ready", req_ready_o, 0);
        chk("t5_conn_ready", conn_ready_o, 0);
        chk("t5_rsp_valid", rsp_valid_o, 0);
        chk("t5_lookups", lookups_o, 0);
        chk("t5_grant", grant_o, 0);
        clear_model();

        push_lookup(0, 32'h0A000900, 32'h0A000A00, 32'h00010002, 32'h00000006, 32'h00006060);
        push_lookup(2, 32'h0A000902, 32'h0A000A02, 32'h00030004, 32'h00000011, 32'h00006262);
        run_idle(300);
        chk("t5_rr_lookups", lookups_o, 2);
        chk("t5_rr_last_grant", grant_o, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
